// File: rtl/intersection_phase_scheduler_pkg.sv
// intersection_phase_scheduler_pkg: phase encodings, lamp patterns and the BCD decrement
// shared by the scheduler and its countdown.
package intersection_phase_scheduler_pkg;
    typedef enum logic [2:0] {AR1, NSG, NSY, AR2, EWG, EWY, PED1, PED2} phase_t;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    // Borrow turns the low digit into 9 so NUM never holds a non-BCD digit.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        return v[3:0] != 4'd0 ? {v[7:4], v[3:0] - 4'd1} : {v[7:4] - 4'd1, 4'd9};
    endfunction
endpackage

// File: rtl/intersection_phase_scheduler_bcd_countdown.sv
// intersection_phase_scheduler_bcd_countdown: 2-digit BCD down counter.
// It loads a phase time and decrements until it reaches zero.
module intersection_phase_scheduler_bcd_countdown
    import intersection_phase_scheduler_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = 8'h02
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec,
    output logic [7:0] num,
    output logic       zero
);
    assign zero = num == 8'h00;
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) num <= RESET_VALUE;
        else if (load) num <= load_value;
        else if (dec && !zero) num <= bcd_dec(num);
    end
endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: two-road signal sequencer with an inserted pedestrian walk phase,
// a one-second tick and a per-phase BCD countdown.
module intersection_phase_scheduler
    import intersection_phase_scheduler_pkg::*;
#(
    parameter int         ONE_SECOND    = 8,
    parameter logic [7:0] NS_GREEN_TIME = 8'h25,
    parameter logic [7:0] EW_GREEN_TIME = 8'h20,
    parameter logic [7:0] YELLOW_TIME   = 8'h03,
    parameter logic [7:0] ALL_RED_TIME  = 8'h02,
    parameter logic [7:0] PED_TIME      = 8'h10,
    parameter logic [7:0] BLINK_TIME    = 8'h03
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       PED_REQ,
    output logic       PED_ACK,
    output logic [2:0] NS_LIGHT,
    output logic [2:0] EW_LIGHT,
    output logic       PED_WALK,
    output logic [2:0] PHASE,
    output logic [7:0] NUM,
    output logic       TICK
);
    localparam int CW = ONE_SECOND > 1 ? $clog2(ONE_SECOND) : 1;
    logic [CW-1:0] tick_cnt;
    phase_t        state, state_nxt;
    logic [7:0]    load_value;
    logic          zero, expire, pending, enter_ped, in_ped;
    assign TICK      = tick_cnt == CW'(ONE_SECOND - 1);
    assign expire    = TICK && zero;
    assign enter_ped = expire && (state_nxt == PED1 || state_nxt == PED2);
    assign in_ped    = state == PED1 || state == PED2;
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) tick_cnt <= '0;
        else tick_cnt <= TICK ? '0 : tick_cnt + 1'b1;
    end
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= AR1;
        else if (expire) state <= state_nxt;
    end
    // Entering a walk phase consumes the request, even if the button is held on that edge.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) pending <= 1'b0;
        else if (enter_ped) pending <= 1'b0;
        else if (PED_REQ) pending <= 1'b1;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            AR1:  state_nxt = pending ? PED1 : NSG;
            NSG:  state_nxt = NSY;
            NSY:  state_nxt = AR2;
            AR2:  state_nxt = pending ? PED2 : EWG;
            EWG:  state_nxt = EWY;
            EWY:  state_nxt = AR1;
            PED1: state_nxt = NSG;
            PED2: state_nxt = EWG;
        endcase
        load_value = state_nxt == NSG ? NS_GREEN_TIME :
                     state_nxt == EWG ? EW_GREEN_TIME :
                     (state_nxt == NSY || state_nxt == EWY) ? YELLOW_TIME :
                     (state_nxt == PED1 || state_nxt == PED2) ? PED_TIME : ALL_RED_TIME;
    end
    intersection_phase_scheduler_bcd_countdown #(.RESET_VALUE(ALL_RED_TIME)) u_countdown (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .load       (expire),
        .load_value (load_value),
        .dec        (TICK),
        .num        (NUM),
        .zero       (zero)
    );
    assign PHASE    = state;
    assign PED_ACK  = pending;
    assign NS_LIGHT = state == NSG ? GRN : state == NSY ? YEL : RED;
    assign EW_LIGHT = state == EWG ? GRN : state == EWY ? YEL : RED;
    assign PED_WALK = in_ped && !(NUM <= BLINK_TIME && tick_cnt < CW'(ONE_SECOND / 2));
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: directed vectors with hand-computed phase timing (ONE_SECOND=8).
module tb_intersection_phase_scheduler;
    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       PED_REQ;
    logic       PED_ACK;
    logic [2:0] NS_LIGHT;
    logic [2:0] EW_LIGHT;
    logic       PED_WALK;
    logic [2:0] PHASE;
    logic [7:0] NUM;
    logic       TICK;
    int n_cmp = 0;
    int n_err = 0;

    intersection_phase_scheduler dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .PED_REQ  (PED_REQ),
        .PED_ACK  (PED_ACK),
        .NS_LIGHT (NS_LIGHT),
        .EW_LIGHT (EW_LIGHT),
        .PED_WALK (PED_WALK),
        .PHASE    (PHASE),
        .NUM      (NUM),
        .TICK     (TICK)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic pulse_req();
        PED_REQ = 1'b1;
        cycles(1);
        PED_REQ = 1'b0;
    endtask

    // Lamp safety watched on every out-of-reset falling edge.
    always @(negedge CLOCK) begin
        if (!RESET) begin
            chk("mutex", 32'(NS_LIGHT != 3'b100 && EW_LIGHT != 3'b100), 0);
            chk("ns_onehot", 32'($onehot(NS_LIGHT)), 1);
            chk("ew_onehot", 32'($onehot(EW_LIGHT)), 1);
        end
    end

    initial begin
        RESET   = 1'b1;
        PED_REQ = 1'b0;
        #1;
        chk("rst_phase", PHASE, 0);
        chk("rst_num", NUM, 8'h02);
        chk("rst_ns", NS_LIGHT, 3'b100);
        chk("rst_ew", EW_LIGHT, 3'b100);
        chk("rst_walk", PED_WALK, 0);
        chk("rst_ack", PED_ACK, 0);
        chk("rst_tick", TICK, 0);
        cycles(2);
        RESET = 1'b0;
        // Startup: AR1 lasts 3 ticks, then NSG loads 25.
        cycles(7);
        chk("tick_hi", TICK, 1);
        chk("ar1_num02", NUM, 8'h02);
        cycles(1);
        chk("tick_lo", TICK, 0);
        chk("ar1_num01", NUM, 8'h01);
        cycles(16);
        chk("nsg_phase", PHASE, 1);
        chk("nsg_ns", NS_LIGHT, 3'b001);
        chk("nsg_ew", EW_LIGHT, 3'b100);
        chk("nsg_num", NUM, 8'h25);
        // BCD borrows.
        cycles(40);
        chk("num20", NUM, 8'h20);
        cycles(8);
        chk("num19", NUM, 8'h19);
        cycles(72);
        chk("num10", NUM, 8'h10);
        cycles(8);
        chk("num09", NUM, 8'h09);
        pulse_req();
        chk("ack_set", PED_ACK, 1);
        cycles(79);
        chk("nsy_phase", PHASE, 2);
        chk("nsy_ns", NS_LIGHT, 3'b010);
        chk("nsy_num", NUM, 8'h03);
        chk("nsy_ack", PED_ACK, 1);
        // NSY 4 ticks + AR2 3 ticks, then the pending request takes PED2.
        cycles(56);
        chk("ped2_phase", PHASE, 7);
        chk("ped2_ack", PED_ACK, 0);
        chk("ped2_walk", PED_WALK, 1);
        chk("ped2_num", NUM, 8'h10);
        chk("ped2_ns", NS_LIGHT, 3'b100);
        chk("ped2_ew", EW_LIGHT, 3'b100);
        cycles(48);
        chk("num04", NUM, 8'h04);
        chk("walk04_c0", PED_WALK, 1);
        cycles(8);
        chk("num03", NUM, 8'h03);
        chk("blink_c0", PED_WALK, 0);
        cycles(3);
        chk("blink_c3", PED_WALK, 0);
        cycles(1);
        chk("blink_c4", PED_WALK, 1);
        cycles(3);
        chk("blink_c7", PED_WALK, 1);
        cycles(25);
        chk("ewg_phase", PHASE, 4);
        chk("ewg_ew", EW_LIGHT, 3'b001);
        chk("ewg_ns", NS_LIGHT, 3'b100);
        chk("ewg_num", NUM, 8'h20);
        chk("ewg_walk", PED_WALK, 0);
        // Request during EWG, then hold the button on the edge that enters PED1.
        pulse_req();
        chk("ack_ewg", PED_ACK, 1);
        cycles(222);
        chk("ar1_end_phase", PHASE, 0);
        chk("ar1_end_num", NUM, 8'h00);
        chk("ar1_end_tick", TICK, 1);
        PED_REQ = 1'b1;
        cycles(1);
        PED_REQ = 1'b0;
        chk("ped1_phase", PHASE, 6);
        chk("ped1_ack_clr", PED_ACK, 0);
        chk("ped1_num", NUM, 8'h10);
        cycles(1);
        chk("ped1_ack_stay", PED_ACK, 0);
        pulse_req();
        chk("ped1_ack_reset", PED_ACK, 1);
        chk("ped1_still", PHASE, 6);
        cycles(86);
        chk("nsg2_phase", PHASE, 1);
        chk("nsg2_num", NUM, 8'h25);
        chk("nsg2_ack", PED_ACK, 1);
        cycles(264);
        chk("ped2b_phase", PHASE, 7);
        chk("ped2b_ack", PED_ACK, 0);
        cycles(88);
        chk("ewg2_phase", PHASE, 1 + 3);
        // Asynchronous reset mid-EWG with a request pending.
        pulse_req();
        chk("ewg2_ack", PED_ACK, 1);
        cycles(3);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_ns", NS_LIGHT, 3'b100);
        chk("arst_ew", EW_LIGHT, 3'b100);
        chk("arst_num", NUM, 8'h02);
        chk("arst_phase", PHASE, 0);
        chk("arst_ack", PED_ACK, 0);
        chk("arst_tick", TICK, 0);
        cycles(2);
        RESET = 1'b0;
        // Full request-free period: 61 ticks = 488 cycles.
        cycles(487);
        chk("period_ewy", PHASE, 5);
        chk("period_ewy_num", NUM, 8'h00);
        chk("period_ewy_ew", EW_LIGHT, 3'b010);
        cycles(1);
        chk("period_ar1", PHASE, 0);
        chk("period_ar1_num", NUM, 8'h02);
        chk("period_ack", PED_ACK, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
